// File: rtl/pipeline_pkg.sv
// Shared pipeline types: address and instruction widths, and the fetch-queue entry layout.
package pipeline_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage : pipeline_pkg

// File: rtl/fq_ram.sv
// Fetch-queue storage: DEPTH entries, one synchronous write port and one asynchronous read port.
module fq_ram
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  fq_entry_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output fq_entry_t       rd_data
);

    // Contents are never cleared; head/tail/count alone decide what is valid.
    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : fq_ram

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: head/tail/count ring over fq_ram, no bypass.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;
    fq_entry_t        wr_entry;
    fq_entry_t        rd_entry;

    // Flush masks both handshakes, so a same-cycle push or pop is simply never taken.
    always_comb begin
        in_ready  = (count < CNT_W'(DEPTH)) && !flush;
        out_valid = (count != '0) && !flush;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        wr_entry.pc    = in_pc;
        wr_entry.instr = in_instr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && reset),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (rd_entry)
    );

    always_comb begin
        out_pc    = out_valid ? rd_entry.pc    : '0;
        out_instr = out_valid ? rd_entry.instr : '0;
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    ent_t mq[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Reference: a plain FIFO of accepted entries; called at negedge with inputs already driven.
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = in_valid && (mq.size() < DEPTH) && !flush;
        do_pop  = (mq.size() > 0) && !flush && out_ready;
        e.pc    = in_pc;
        e.instr = in_instr;
        @(posedge clk);
        if (!reset || flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [63:0] pc, input bit ordy, input bit fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 64'hDEAD_0000, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_pc !== 64'h0) begin
            failures++; $display("FAIL reset_out_pc: got %h want 0", out_pc);
        end
    endtask

    task automatic test_latency_order();
        logic [63:0] exp_pc;
        do_reset();
        drive(1'b1, 64'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL lat_no_bypass: out_valid got %b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            failures++; $display("FAIL lat_first_visible: out_valid=%b out_pc=%h want 1/0", out_valid, out_pc);
        end
        drive(1'b1, 64'h4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h8, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3 || out_pc !== 64'h0) begin
            failures++; $display("FAIL lat_count3: count=%0d out_pc=%h want 3/0", count, out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            exp_pc = 64'(i * 4);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                failures++;
                $display("FAIL order_pop%0d: valid=%b pc=%h instr=%h want pc=%h", i, out_valid, out_pc, out_instr, exp_pc);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL order_empty: valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_full();
        logic [63:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h10 + 64'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h20, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            failures++; $display("FAIL full_block: in_ready=%b count=%0d want 0/4", in_ready, count);
        end
        tick();
        checks++;
        if (count !== 3'd4) begin
            failures++; $display("FAIL full_hold: count=%0d want 4", count);
        end
        drive(1'b1, 64'h20, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL full_no_bypass: in_ready=%b want 0", in_ready);
        end
        tick();
        drive(1'b1, 64'h20, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd3) begin
            failures++; $display("FAIL full_reopen: in_ready=%b count=%0d want 1/3", in_ready, count);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            exp_pc = 64'h14 + 64'(i * 4);
            checks++;
            if (out_pc !== exp_pc) begin
                failures++; $display("FAIL full_drain%0d: out_pc=%h want %h", i, out_pc, exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        drive(1'b1, 64'h100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h104, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h108, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd2 || out_pc !== 64'h104) begin
            failures++; $display("FAIL simul: count=%0d out_pc=%h want 2/104", count, out_pc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h30 + 64'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h40, 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'h0) begin
            failures++; $display("FAIL flush_mask: in_ready=%b out_valid=%b out_pc=%h want 0/0/0", in_ready, out_valid, out_pc);
        end
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_empty: count=%0d out_valid=%b want 0/0", count, out_valid);
        end
        drive(1'b1, 64'h80, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd1 || out_pc !== 64'h80) begin
            failures++; $display("FAIL flush_refill: count=%0d out_pc=%h want 1/80", count, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_no_stale: out_valid=%b out_pc=%h want 0", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] sent[$];
        logic [63:0] exp_pc;
        int          nsent = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sent.push_back(64'h200 + 64'(nsent * 4));
            drive(1'b1, sent[$], 1'b0, 1'b0);
            nsent++;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            sent.push_back(64'h200 + 64'(nsent * 4));
            drive(1'b1, sent[$], 1'b1, 1'b0);
            nsent++;
            exp_pc = sent.pop_front();
            checks++;
            if (out_pc !== exp_pc || count > 3'd4) begin
                failures++; $display("FAIL wrap%0d: out_pc=%h count=%0d want %h <=4", i, out_pc, count, exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        bit          exp_ov;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = $urandom_range(0, 2) != 0;
            in_pc     = {$urandom, $urandom};
            in_instr  = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            exp_ov    = (mq.size() > 0) && !flush;
            exp_pc    = exp_ov ? mq[0].pc : 64'h0;
            exp_instr = exp_ov ? mq[0].instr : 32'h0;
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== exp_ov
                || in_ready !== ((mq.size() < DEPTH) && !flush)
                || out_pc !== exp_pc || out_instr !== exp_instr) begin
                failures++;
                $display("FAIL rand%0d: count=%0d/%0d ov=%b/%b ir=%b pc=%h/%h instr=%h/%h",
                         i, count, mq.size(), out_valid, exp_ov, in_ready, out_pc, exp_pc, out_instr, exp_instr);
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency_order();
        test_full();
        test_simul_push_pop();
        test_flush();
        test_wrap();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, at least 2.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discard all queued entries (branch taken / misprediction).
REQ-005 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port in_pc  input  64  PC of the presented instruction (the fetch stage's imem_addr_F).
REQ-007 SHALL have port in_instr  input  32  instruction word read from imem at in_pc.
REQ-008 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 SHALL have port out_pc  output  64  PC of the head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-012 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 SHALL accept a push when in_valid && in_ready, writing {in_pc, in_instr} at the tail and advancing the tail pointer.
REQ-015 SHALL perform a pop when out_valid && out_ready, advancing the head pointer.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !flush; there is no bypass, so a full queue rejects a push even when a pop occurs in the same cycle.
REQ-017 SHALL drive out_valid = (count > 0) && !flush.
REQ-018 SHALL drive out_pc and out_instr combinationally from the head entry when out_valid is 1, and as 0 otherwise.
REQ-019 SHALL have one-cycle latency: an entry accepted in cycle N is first visible on out_* in cycle N+1; an empty queue never passes input straight to output.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-021 SHALL wrap head and tail pointers modulo DEPTH.
REQ-022 SHALL give flush priority over push and pop: on the following edge count, head and tail become 0 and any same-cycle push or pop is discarded.
REQ-023 SHALL keep storage contents unchanged on pop, flush and reset; only pointers and count change.
REQ-024 SHALL treat out_ready as don't-care while out_valid is 0, and in_* as don't-care while in_valid is 0.
REQ-025 SHALL, as a storage-mode decision, implement the queue with head, tail and count registers; there are no separate FSM states.

Reset
REQ-026 SHALL, on a rising clk edge with reset == 0, set head, tail and count to 0, giving in_ready = 1, out_valid = 0 and out_pc = out_instr = 0 in the following cycle.
REQ-027 SHALL give reset priority over flush, push and pop, including a reset asserted mid-stream.
REQ-028 SHALL NOT require storage array contents to be reset.

Structure
REQ-029 SHALL take ADDR_W = 64, INSTR_W = 32 and typedef fq_entry_t {pc, instr} from a shared package pipeline_pkg.
REQ-030 SHALL keep the pointer and count logic inline, with one natural sub-module fq_ram (DEPTH x fq_entry_t, 1 write port and 1 async read port).

Verification
REQ-031 SHALL cover reset: hold reset = 0 for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1, out_pc = 0.
REQ-032 SHALL cover latency and order: push pc 0x0, 0x4, 0x8 with out_ready = 0 -> out_valid rises the cycle after the first push, count = 3, out_pc = 0x0; then out_ready = 1 -> pops 0x0, 0x4, 0x8 in order.
REQ-033 SHALL cover full: push 4 entries (pc 0x10..0x1C), then in_valid = 1 with pc 0x20 -> in_ready = 0 and count holds at 4; pop once -> in_ready = 1 the next cycle and 0x20 is accepted, with 0x20 never accepted in the pop cycle.
REQ-034 SHALL cover simultaneous push and pop: with count = 2, push and pop in the same cycle -> count stays 2 and the head advances by one.
REQ-035 SHALL cover flush: with count = 3, flush = 1 together with in_valid = 1 (pc 0x40) -> next cycle count = 0, out_valid = 0, and 0x40 is absent; a push of 0x80 the following cycle -> out_pc = 0x80.
REQ-036 SHALL cover wrap-around: run 10 push/pop pairs at DEPTH = 4 with pc incremented by 4 -> output sequence equals input sequence and count never exceeds 4.
